// File: rtl/vx_tl_mem_arbiter.sv
// Shares one TileLink-UL master port between the icache and dcache request streams.
// Round-robin grant into a registered A stage, per-requester outstanding limits, combinational D routing.
module vx_tl_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int TAG_WIDTH       = 7,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  i_req_valid_i,
  output logic                  i_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_i,
  input  logic [TAG_WIDTH-1:0]  i_req_tag_i,
  output logic                  i_rsp_valid_o,
  input  logic                  i_rsp_ready_i,
  output logic [31:0]           i_rsp_data_o,
  output logic [TAG_WIDTH-1:0]  i_rsp_tag_o,

  input  logic                  d_req_valid_i,
  output logic                  d_req_ready_o,
  input  logic                  d_req_rw_i,
  input  logic [3:0]            d_req_byteen_i,
  input  logic [ADDR_WIDTH-1:0] d_req_addr_i,
  input  logic [31:0]           d_req_data_i,
  input  logic [TAG_WIDTH-1:0]  d_req_tag_i,
  output logic                  d_rsp_valid_o,
  input  logic                  d_rsp_ready_i,
  output logic [31:0]           d_rsp_data_o,
  output logic [TAG_WIDTH-1:0]  d_rsp_tag_o,

  output logic                  mem_a_valid_o,
  input  logic                  mem_a_ready_i,
  output logic [2:0]            mem_a_opcode_o,
  output logic [2:0]            mem_a_param_o,
  output logic [3:0]            mem_a_size_o,
  output logic [TAG_WIDTH:0]    mem_a_source_o,
  output logic [ADDR_WIDTH-1:0] mem_a_address_o,
  output logic [3:0]            mem_a_mask_o,
  output logic [31:0]           mem_a_data_o,
  output logic                  mem_a_corrupt_o,

  input  logic                  mem_d_valid_i,
  output logic                  mem_d_ready_o,
  input  logic [2:0]            mem_d_opcode_i,
  input  logic [TAG_WIDTH:0]    mem_d_source_i,
  input  logic [31:0]           mem_d_data_i,
  input  logic                  mem_d_denied_i,

  output logic                  err_denied_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(3));

  localparam logic [2:0] OP_PUT_FULL  = 3'd0;
  localparam logic [2:0] OP_PUT_PART  = 3'd1;
  localparam logic [2:0] OP_GET       = 3'd4;
  localparam logic [2:0] OP_ACK_DATA  = 3'd1;
  localparam logic [3:0] SIZE_WORD    = 4'd2;

  typedef enum logic {
    RR_ICACHE = 1'b0,
    RR_DCACHE = 1'b1
  } rr_e;

  logic                  a_valid_q;
  logic [2:0]            a_opcode_q,  a_opcode_d;
  logic [3:0]            a_size_q;
  logic [TAG_WIDTH:0]    a_source_q,  a_source_d;
  logic [ADDR_WIDTH-1:0] a_address_q, a_address_d;
  logic [3:0]            a_mask_q,    a_mask_d;
  logic [31:0]           a_data_q,    a_data_d;

  rr_e                   rr_q, rr_d;
  logic [CW-1:0]         i_cnt_q, i_cnt_d;
  logic [CW-1:0]         d_cnt_q, d_cnt_d;
  logic                  err_q, err_d;

  logic slot_free, i_elig, d_elig, grant_i, grant_d;
  logic d_sel, d_is_data, d_fire, i_dec, d_dec;

  // ---------------- arbitration ----------------
  assign slot_free = !a_valid_q || mem_a_ready_i;
  assign i_elig    = i_req_valid_i && (i_cnt_q < MAX_CNT);
  assign d_elig    = d_req_valid_i && (d_cnt_q < MAX_CNT);
  assign grant_i   = slot_free && i_elig && (!d_elig || rr_q == RR_ICACHE);
  assign grant_d   = slot_free && d_elig && (!i_elig || rr_q == RR_DCACHE);

  assign i_req_ready_o = grant_i;
  assign d_req_ready_o = grant_d;

  always_comb begin
    rr_d = rr_q;
    if (grant_i)      rr_d = RR_DCACHE;
    else if (grant_d) rr_d = RR_ICACHE;
  end

  // Requests are always whole-word accesses; the byte enables only shape the mask.
  always_comb begin
    a_opcode_d  = OP_GET;
    a_mask_d    = 4'hF;
    a_source_d  = {1'b0, i_req_tag_i};
    a_address_d = i_req_addr_i & ADDR_MASK;
    a_data_d    = '0;
    if (grant_d) begin
      a_source_d  = {1'b1, d_req_tag_i};
      a_address_d = d_req_addr_i & ADDR_MASK;
      if (d_req_rw_i) begin
        a_opcode_d = (d_req_byteen_i == 4'hF) ? OP_PUT_FULL : OP_PUT_PART;
        a_mask_d   = d_req_byteen_i;
        a_data_d   = d_req_data_i;
      end
    end
  end

  // ---------------- D routing ----------------
  assign d_sel     = mem_d_source_i[TAG_WIDTH];
  assign d_is_data = (mem_d_opcode_i == OP_ACK_DATA);

  // Dcache write acks carry nothing for the core, so they are swallowed here.
  assign mem_d_ready_o = !d_sel ? i_rsp_ready_i : (d_is_data ? d_rsp_ready_i : 1'b1);
  assign d_fire        = mem_d_valid_i && mem_d_ready_o;

  assign i_rsp_valid_o = mem_d_valid_i && !d_sel;
  assign i_rsp_data_o  = mem_d_data_i;
  assign i_rsp_tag_o   = mem_d_source_i[TAG_WIDTH-1:0];
  assign d_rsp_valid_o = mem_d_valid_i && d_sel && d_is_data;
  assign d_rsp_data_o  = mem_d_data_i;
  assign d_rsp_tag_o   = mem_d_source_i[TAG_WIDTH-1:0];

  // Beats for a requester with nothing in flight are stale and must not underflow.
  assign i_dec = d_fire && !d_sel && (i_cnt_q != '0);
  assign d_dec = d_fire &&  d_sel && (d_cnt_q != '0);

  always_comb begin
    i_cnt_d = i_cnt_q;
    if (grant_i && !i_dec)      i_cnt_d = i_cnt_q + CW'(1);
    else if (!grant_i && i_dec) i_cnt_d = i_cnt_q - CW'(1);
  end

  always_comb begin
    d_cnt_d = d_cnt_q;
    if (grant_d && !d_dec)      d_cnt_d = d_cnt_q + CW'(1);
    else if (!grant_d && d_dec) d_cnt_d = d_cnt_q - CW'(1);
  end

  assign err_d = err_q || (d_fire && mem_d_denied_i);

  // ---------------- state ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      rr_q        <= RR_ICACHE;
      i_cnt_q     <= '0;
      d_cnt_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (grant_i || grant_d) begin
        a_valid_q   <= 1'b1;
        a_opcode_q  <= a_opcode_d;
        a_size_q    <= SIZE_WORD;
        a_source_q  <= a_source_d;
        a_address_q <= a_address_d;
        a_mask_q    <= a_mask_d;
        a_data_q    <= a_data_d;
      end else if (mem_a_ready_i) begin
        a_valid_q   <= 1'b0;
      end
      rr_q    <= rr_d;
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_a_valid_o   = a_valid_q;
  assign mem_a_opcode_o  = a_opcode_q;
  assign mem_a_param_o   = 3'd0;
  assign mem_a_size_o    = a_size_q;
  assign mem_a_source_o  = a_source_q;
  assign mem_a_address_o = a_address_q;
  assign mem_a_mask_o    = a_mask_q;
  assign mem_a_data_o    = a_data_q;
  assign mem_a_corrupt_o = 1'b0;

  assign err_denied_o = err_q;
  assign busy_o       = a_valid_q || (i_cnt_q != '0) || (d_cnt_q != '0);

endmodule

// File: tb/tb_vx_tl_mem_arbiter.sv
// Directed bench for vx_tl_mem_arbiter: arbitration order, limits, A encoding, stall, D routing, reset.
module tb_vx_tl_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic [6:0]  i_req_tag;
  logic        i_rsp_valid, i_rsp_ready;
  logic [31:0] i_rsp_data;
  logic [6:0]  i_rsp_tag;
  logic        d_req_valid, d_req_ready, d_req_rw;
  logic [3:0]  d_req_byteen;
  logic [31:0] d_req_addr, d_req_data;
  logic [6:0]  d_req_tag;
  logic        d_rsp_valid, d_rsp_ready;
  logic [31:0] d_rsp_data;
  logic [6:0]  d_rsp_tag;
  logic        mem_a_valid, mem_a_ready;
  logic [2:0]  mem_a_opcode, mem_a_param;
  logic [3:0]  mem_a_size;
  logic [7:0]  mem_a_source;
  logic [31:0] mem_a_address;
  logic [3:0]  mem_a_mask;
  logic [31:0] mem_a_data;
  logic        mem_a_corrupt;
  logic        mem_d_valid, mem_d_ready;
  logic [2:0]  mem_d_opcode;
  logic [7:0]  mem_d_source;
  logic [31:0] mem_d_data;
  logic        mem_d_denied;
  logic        err_denied, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_tl_mem_arbiter #(.ADDR_WIDTH(32), .TAG_WIDTH(7), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_valid_i(i_req_valid), .i_req_ready_o(i_req_ready), .i_req_addr_i(i_req_addr),
    .i_req_tag_i(i_req_tag), .i_rsp_valid_o(i_rsp_valid), .i_rsp_ready_i(i_rsp_ready),
    .i_rsp_data_o(i_rsp_data), .i_rsp_tag_o(i_rsp_tag),
    .d_req_valid_i(d_req_valid), .d_req_ready_o(d_req_ready), .d_req_rw_i(d_req_rw),
    .d_req_byteen_i(d_req_byteen), .d_req_addr_i(d_req_addr), .d_req_data_i(d_req_data),
    .d_req_tag_i(d_req_tag), .d_rsp_valid_o(d_rsp_valid), .d_rsp_ready_i(d_rsp_ready),
    .d_rsp_data_o(d_rsp_data), .d_rsp_tag_o(d_rsp_tag),
    .mem_a_valid_o(mem_a_valid), .mem_a_ready_i(mem_a_ready), .mem_a_opcode_o(mem_a_opcode),
    .mem_a_param_o(mem_a_param), .mem_a_size_o(mem_a_size), .mem_a_source_o(mem_a_source),
    .mem_a_address_o(mem_a_address), .mem_a_mask_o(mem_a_mask), .mem_a_data_o(mem_a_data),
    .mem_a_corrupt_o(mem_a_corrupt),
    .mem_d_valid_i(mem_d_valid), .mem_d_ready_o(mem_d_ready), .mem_d_opcode_i(mem_d_opcode),
    .mem_d_source_i(mem_d_source), .mem_d_data_i(mem_d_data), .mem_d_denied_i(mem_d_denied),
    .err_denied_o(err_denied), .busy_o(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_valid = 0; i_req_addr = '0; i_req_tag = '0; i_rsp_ready = 0;
    d_req_valid = 0; d_req_rw = 0; d_req_byteen = '0; d_req_addr = '0; d_req_data = '0;
    d_req_tag = '0; d_rsp_ready = 0; mem_a_ready = 0;
    mem_d_valid = 0; mem_d_opcode = '0; mem_d_source = '0; mem_d_data = '0; mem_d_denied = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #3;
    checks++; if (mem_a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %0h exp 0", mem_a_valid); end
    checks++; if (mem_a_address !== 32'h0) begin errors++; $display("FAIL reset_a_address got %0h exp 0", mem_a_address); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (err_denied !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", err_denied); end
    tick();
    rst_n = 1;
    tick();
    i_req_valid = 1;
    #1;
    checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready_follow got %0h exp 1", i_req_ready); end
    i_req_valid = 0;
    #1;
    checks++; if (i_req_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready_drop got %0h exp 0", i_req_ready); end
  endtask

  task automatic test_round_robin();
    logic exp_i;
    i_req_valid = 1; i_req_tag = 7'h11; i_req_addr = 32'h100;
    d_req_valid = 1; d_req_rw = 0; d_req_tag = 7'h22; d_req_addr = 32'h200;
    mem_a_ready = 1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_i = (k % 2 == 0);
      checks++; if (i_req_ready !== exp_i) begin errors++; $display("FAIL rr_i_ready[%0d] got %0h exp %0h", k, i_req_ready, exp_i); end
      checks++; if (d_req_ready !== !exp_i) begin errors++; $display("FAIL rr_d_ready[%0d] got %0h exp %0h", k, d_req_ready, !exp_i); end
      tick();
      checks++; if (mem_a_valid !== 1'b1) begin errors++; $display("FAIL rr_a_valid[%0d] got %0h exp 1", k, mem_a_valid); end
      checks++; if (mem_a_source !== (exp_i ? 8'h11 : 8'hA2)) begin errors++; $display("FAIL rr_source[%0d] got %0h exp %0h", k, mem_a_source, exp_i ? 8'h11 : 8'hA2); end
    end
    i_req_valid = 0; d_req_valid = 0;
    tick();
    checks++; if (mem_a_valid !== 1'b0) begin errors++; $display("FAIL rr_a_drain got %0h exp 0", mem_a_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy_outstanding got %0h exp 1", busy); end
    i_rsp_ready = 1; d_rsp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      mem_d_valid = 1; mem_d_source = 8'h11; mem_d_opcode = 3'd1; mem_d_data = 32'hC0DE0000 + k;
      #1;
      checks++; if (i_rsp_valid !== 1'b1 || i_rsp_tag !== 7'h11 || i_rsp_data !== 32'hC0DE0000 + k) begin
        errors++; $display("FAIL rr_i_rsp[%0d] got v%0h t%0h d%0h exp v1 t11 d%0h", k, i_rsp_valid, i_rsp_tag, i_rsp_data, 32'hC0DE0000 + k); end
      checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_i_rsp_leak[%0d] got %0h exp 0", k, d_rsp_valid); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      mem_d_valid = 1; mem_d_source = 8'hA2; mem_d_opcode = 3'd1; mem_d_data = 32'hBEEF0000 + k;
      #1;
      checks++; if (d_rsp_valid !== 1'b1 || d_rsp_tag !== 7'h22 || d_rsp_data !== 32'hBEEF0000 + k) begin
        errors++; $display("FAIL rr_d_rsp[%0d] got v%0h t%0h d%0h exp v1 t22 d%0h", k, d_rsp_valid, d_rsp_tag, d_rsp_data, 32'hBEEF0000 + k); end
      checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_d_rsp_leak[%0d] got %0h exp 0", k, i_rsp_valid); end
      tick();
    end
    mem_d_valid = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_idle got %0h exp 0", busy); end
  endtask

  task automatic test_outstanding_limit();
    i_req_valid = 1; i_req_tag = 7'h05; i_req_addr = 32'h300; mem_a_ready = 1; i_rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL lim_grant[%0d] got %0h exp 1", k, i_req_ready); end
      tick();
    end
    checks++; if (i_req_ready !== 1'b0) begin errors++; $display("FAIL lim_full got %0h exp 0", i_req_ready); end
    mem_d_valid = 1; mem_d_source = 8'h05; mem_d_opcode = 3'd1;
    #1;
    checks++; if (i_req_ready !== 1'b0) begin errors++; $display("FAIL lim_same_cycle got %0h exp 0", i_req_ready); end
    tick();
    mem_d_valid = 0;
    #1;
    checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL lim_restored got %0h exp 1", i_req_ready); end
    tick();
    checks++; if (i_req_ready !== 1'b0) begin errors++; $display("FAIL lim_one_only got %0h exp 0", i_req_ready); end
    i_req_valid = 0;
    mem_d_valid = 1;
    repeat (4) tick();
    mem_d_valid = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lim_drained got %0h exp 0", busy); end
  endtask

  task automatic test_write_encoding();
    logic        v_rw   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  v_be   [4] = '{4'h3, 4'hF, 4'h0, 4'h3};
    logic [31:0] v_addr [4] = '{32'h1003, 32'h2000, 32'h3002, 32'h4001};
    logic [31:0] v_data [4] = '{32'hDEADBEEF, 32'h12345678, 32'hAAAA5555, 32'h0};
    logic [2:0]  e_op   [4] = '{3'd1, 3'd0, 3'd1, 3'd4};
    logic [3:0]  e_mask [4] = '{4'h3, 4'hF, 4'h0, 4'hF};
    logic [31:0] e_addr [4] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
    mem_a_ready = 1; d_req_tag = 7'h33;
    for (int k = 0; k < 4; k++) begin
      d_req_valid = 1; d_req_rw = v_rw[k]; d_req_byteen = v_be[k]; d_req_addr = v_addr[k]; d_req_data = v_data[k];
      #1;
      checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready[%0d] got %0h exp 1", k, d_req_ready); end
      tick();
      d_req_valid = 0;
      checks++; if (mem_a_valid !== 1'b1 || mem_a_opcode !== e_op[k] || mem_a_size !== 4'd2 || mem_a_param !== 3'd0) begin
        errors++; $display("FAIL wr_hdr[%0d] got v%0h op%0h sz%0h pa%0h exp v1 op%0h sz2 pa0", k, mem_a_valid, mem_a_opcode, mem_a_size, mem_a_param, e_op[k]); end
      checks++; if (mem_a_mask !== e_mask[k] || mem_a_address !== e_addr[k]) begin
        errors++; $display("FAIL wr_mask_addr[%0d] got m%0h a%0h exp m%0h a%0h", k, mem_a_mask, mem_a_address, e_mask[k], e_addr[k]); end
      checks++; if (mem_a_data !== v_data[k] || mem_a_source !== 8'hB3 || mem_a_corrupt !== 1'b0) begin
        errors++; $display("FAIL wr_data_src[%0d] got d%0h s%0h c%0h exp d%0h sB3 c0", k, mem_a_data, mem_a_source, mem_a_corrupt, v_data[k]); end
    end
    d_req_valid = 1; d_req_rw = 0;
    #1;
    checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL ack_full got %0h exp 0", d_req_ready); end
    d_req_valid = 0; d_rsp_ready = 0;
    mem_d_valid = 1; mem_d_source = 8'hB3; mem_d_opcode = 3'd0; mem_d_data = 32'h0;
    #1;
    checks++; if (d_rsp_valid !== 1'b0 || mem_d_ready !== 1'b1) begin
      errors++; $display("FAIL ack_absorb got v%0h r%0h exp v0 r1", d_rsp_valid, mem_d_ready); end
    tick();
    mem_d_valid = 0; d_req_valid = 1;
    #1;
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL ack_decrement got %0h exp 1", d_req_ready); end
    d_req_valid = 0;
    mem_d_valid = 1;
    repeat (3) tick();
    mem_d_valid = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ack_drained got %0h exp 0", busy); end
  endtask

  task automatic test_stall();
    i_req_valid = 1; i_req_tag = 7'h11; i_req_addr = 32'h1237;
    d_req_valid = 1; d_req_rw = 0; d_req_tag = 7'h22; d_req_addr = 32'h200;
    mem_a_ready = 0;
    #1;
    checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL stall_first got %0h exp 1", i_req_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (mem_a_valid !== 1'b1 || mem_a_source !== 8'h11 || mem_a_address !== 32'h1234) begin
        errors++; $display("FAIL stall_hold[%0d] got v%0h s%0h a%0h exp v1 s11 a1234", k, mem_a_valid, mem_a_source, mem_a_address); end
      checks++; if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_no_grant[%0d] got i%0h d%0h exp i0 d0", k, i_req_ready, d_req_ready); end
      tick();
    end
    mem_a_ready = 1;
    #1;
    checks++; if (d_req_ready !== 1'b1 || i_req_ready !== 1'b0) begin
      errors++; $display("FAIL stall_release got i%0h d%0h exp i0 d1", i_req_ready, d_req_ready); end
    tick();
    checks++; if (mem_a_source !== 8'hA2 || mem_a_address !== 32'h200) begin
      errors++; $display("FAIL stall_next got s%0h a%0h exp sA2 a200", mem_a_source, mem_a_address); end
    i_req_valid = 0; d_req_valid = 0;
    tick();
  endtask

  task automatic test_denied();
    i_rsp_ready = 1; d_rsp_ready = 1;
    mem_d_valid = 1; mem_d_source = 8'h11; mem_d_opcode = 3'd1; mem_d_data = 32'h5A5A5A5A; mem_d_denied = 1;
    #1;
    checks++; if (i_rsp_data !== 32'h5A5A5A5A || err_denied !== 1'b0) begin
      errors++; $display("FAIL den_pass got d%0h e%0h exp d5A5A5A5A e0", i_rsp_data, err_denied); end
    tick();
    mem_d_denied = 0;
    mem_d_source = 8'hA2; mem_d_data = 32'h1;
    #1;
    checks++; if (err_denied !== 1'b1) begin errors++; $display("FAIL den_set got %0h exp 1", err_denied); end
    tick();
    mem_d_valid = 0;
    #1;
    checks++; if (err_denied !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL den_sticky got e%0h b%0h exp e1 b0", err_denied, busy); end
  endtask

  task automatic test_zero_count();
    d_rsp_ready = 0; i_rsp_ready = 1;
    mem_d_valid = 1; mem_d_source = 8'h81; mem_d_opcode = 3'd0;
    #1;
    checks++; if (mem_d_ready !== 1'b1 || d_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL zero_ack got r%0h v%0h exp r1 v0", mem_d_ready, d_rsp_valid); end
    tick();
    mem_d_source = 8'h05; mem_d_opcode = 3'd1;
    tick();
    mem_d_valid = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %0h exp 0", busy); end
    i_req_valid = 1; d_req_valid = 1; mem_a_ready = 1;
    #1;
    checks++; if (i_req_ready !== 1'b1 && d_req_ready !== 1'b1) begin
      errors++; $display("FAIL zero_no_underflow got i%0h d%0h exp one ready", i_req_ready, d_req_ready); end
    checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL zero_i_eligible got %0h exp 1", i_req_ready); end
    i_req_valid = 0;
    #1;
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL zero_d_eligible got %0h exp 1", d_req_ready); end
    d_req_valid = 0;
  endtask

  task automatic test_reset_midop();
    i_req_valid = 1; i_req_tag = 7'h07; i_req_addr = 32'h500; mem_a_ready = 1;
    repeat (3) tick();
    i_req_valid = 0; mem_a_ready = 0;
    #1;
    checks++; if (mem_a_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre got v%0h b%0h exp v1 b1", mem_a_valid, busy); end
    #1;
    rst_n = 0;
    #1;
    checks++; if (mem_a_valid !== 1'b0 || mem_a_source !== 8'h0 || mem_a_address !== 32'h0) begin
      errors++; $display("FAIL mid_a_clear got v%0h s%0h a%0h exp 0", mem_a_valid, mem_a_source, mem_a_address); end
    checks++; if (mem_a_opcode !== 3'd0 || mem_a_mask !== 4'h0 || mem_a_size !== 4'h0) begin
      errors++; $display("FAIL mid_a_fields got op%0h m%0h sz%0h exp 0", mem_a_opcode, mem_a_mask, mem_a_size); end
    checks++; if (busy !== 1'b0 || err_denied !== 1'b0) begin
      errors++; $display("FAIL mid_flags got b%0h e%0h exp b0 e0", busy, err_denied); end
    tick();
    rst_n = 1;
    tick();
    i_req_valid = 1; d_req_valid = 1; mem_a_ready = 1;
    #1;
    checks++; if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rr_reset got i%0h d%0h exp i1 d0", i_req_ready, d_req_ready); end
    i_req_valid = 0; d_req_valid = 0;
    i_rsp_ready = 1; mem_d_valid = 1; mem_d_source = 8'h07; mem_d_opcode = 3'd1;
    tick();
    mem_d_valid = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_late_drop got %0h exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_outstanding_limit();
    test_write_encoding();
    test_stall();
    test_denied();
    test_zero_count();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
